sd_cmd_responder: RTL
=====================

# sd_cmd_responder

Card-side responder for the SD CMD line, the counterpart of the host's bit-banged CMD PIO. It deserialises 48-bit host command frames from the single-wire CMD line clocked by the host-driven `sd_clk`, checks the framing and CRC7, and presents the command to local logic. It then serialises a 48-bit response frame back onto the same line. It is used as an on-FPGA SD card model, so the Nios SD driver can run in loopback without a physical card.

## Interface
- `NCR`, default 2: `sd_clk` falling edges from response acceptance to the response start bit. Legal range 2..64.
- `clk`  in  1  system clock; must be at least 8× the `sd_clk` frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sd_clk`  in  1  host SD clock, asynchronous to `clk`.
- `sd_cmd_in`  in  1  CMD line as seen at the pad.
- `sd_cmd_out`  out  1  CMD drive value.
- `sd_cmd_oe`  out  1  CMD output enable; the pad drives `sd_cmd_out` when this is 1.
- `cmd_valid`  out  1  one-`clk` pulse: a good command frame was received.
- `cmd_err`  out  1  one-`clk` pulse: a received frame failed the framing or CRC check.
- `cmd_index`  out  6  index of the last received frame; held until the next frame.
- `cmd_arg`  out  32  argument of the last received frame; held until the next frame.
- `resp_ready`  out  1  high while a response is awaited.
- `resp_valid`  in  1  send a response; accepted when `resp_valid & resp_ready`.
- `resp_drop`  in  1  no response for this command; accepted when `resp_drop & resp_ready`.
- `resp_index`  in  6  response index, sampled at acceptance.
- `resp_arg`  in  32  response argument, sampled at acceptance.

## Operation
- Synchronisation: `sd_clk` and `sd_cmd_in` each pass through 2 flops. Rise and fall events are detected in the `clk` domain.
- Sampling and driving: CMD is sampled on rise events. `sd_cmd_out` changes only on fall events.
- Reset values: `sd_cmd_out` = 1, `sd_cmd_oe` = 0, `cmd_valid` = 0, `cmd_err` = 0, `resp_ready` = 0, `cmd_index` = 0, `cmd_arg` = 0. State is IDLE.
- IDLE: a sampled 0 starts reception and moves to RX.
- RX: shifts in the remaining 47 bits, then goes to CHECK.
- CHECK (1 `clk`): the frame must have transmission bit = 1, end bit = 1, and CRC7 over bits 47..8 equal to bits 7..1.
  - Pass: pulse `cmd_valid`, load `cmd_index`/`cmd_arg`, go to WAIT.
  - Fail: pulse `cmd_err`, go to IDLE.
- WAIT: `resp_ready` = 1.
  - Drop accepted → IDLE. If `resp_valid` and `resp_drop` are both high, drop wins.
  - Valid accepted → NCR state.
  - A sampled 0 on CMD (new host command) abandons the pending response: `resp_ready` falls, state goes to RX, and that sampled bit counts as the start bit.
- NCR: counts `NCR` fall events. On the last one, drive the start bit and set `sd_cmd_oe` = 1, then go to TX.
- TX: one bit per fall event, MSB first: start 0, transmission bit 0, `resp_index`, `resp_arg`, CRC7, end 1. On the fall event after the end bit, `sd_cmd_oe` = 0 and `sd_cmd_out` = 1, then IDLE.
- CRC7: polynomial x⁷+x³+1, initial value 0, computed serially on the bits as they pass.
- Rise events while `sd_cmd_oe` = 1 are ignored; there is no echo reception.
- Reset asserted mid-frame: `sd_cmd_oe` drops asynchronously and the partial frame is discarded without a `cmd_err` pulse.

## Timing
- `cmd_valid`/`cmd_err` pulse exactly 1 `clk` after the `clk` in which the end-bit rise is detected.
- Event detection lags the pad edge by 2–3 `clk` cycles.
- Response start bit appears on the `NCR`th fall event after acceptance. Each response bit is held for one full `sd_clk` period.
- `resp_ready` falls in the `clk` after acceptance.
- If `sd_clk` stops, every state holds indefinitely; there are no timeouts.

## Configuration
- `SD_CMD_RX_CRC_EN` defined: received-CRC check active as described above.
- `SD_CMD_RX_CRC_EN` undefined:
  - Only the transmission and end bits are checked; a bad CRC still yields `cmd_valid`.
  - CRC7 logic is generated for TX only.

## Test plan
- CMD0 frame 0x40_00000000_95 → `cmd_valid`, `cmd_index` = 0, `cmd_arg` = 0. Then `resp_drop` → IDLE, `sd_cmd_oe` never asserts.
- CMD17 frame 0x51_00000000_55, then `resp_valid` with index 17, arg 0, `NCR` = 2 → line carries 0x11_00000000_C1, start bit on the 2nd fall after acceptance, `sd_cmd_oe` low after the end bit.
- CMD55 frame with CRC byte corrupted 0x65→0x67 → with `SD_CMD_RX_CRC_EN`: `cmd_err` pulse, no `resp_ready`. Without it: `cmd_valid`, index 55.
- Frame 0x00_00000000_xx (transmission bit 0) → `cmd_err` in both configurations.
- In WAIT, host sends CMD17 again without a response → `resp_ready` drops at the start bit, second `cmd_valid` follows.
- `reset_n` pulsed at response bit 20 → `sd_cmd_oe` = 0 immediately. A subsequent CMD0 is received normally.

Source files
------------

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD responder: receives 48-bit host commands on sd_cmd_in, sends 48-bit responses.
// Define SD_CMD_RX_CRC_EN to also reject received frames whose CRC7 does not match.
module sd_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_clk,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        resp_ready,
    input  logic        resp_valid,
    input  logic        resp_drop,
    input  logic [5:0]  resp_index,
    input  logic [31:0] resp_arg,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WAIT, S_NCR, S_TX} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  sd_clk_sync_q, sd_clk_sync_d;
    logic [1:0]  cmd_sync_q, cmd_sync_d;
    logic [46:0] rx_shift_q, rx_shift_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [39:0] tx_shift_q, tx_shift_d;
    logic [6:0]  tx_crc_q, tx_crc_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic [5:0]  ncr_cnt_q, ncr_cnt_d;
    logic        sd_cmd_out_q, sd_cmd_out_d;
    logic        sd_cmd_oe_q, sd_cmd_oe_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        resp_ready_q, resp_ready_d;

    logic        rise, fall, cmd_bit;
    logic [47:0] rx_frame;
    logic        frame_ok;

    assign rise     = sd_clk_sync_q[1] & ~sd_clk_sync_q[2];
    assign fall     = ~sd_clk_sync_q[1] & sd_clk_sync_q[2];
    assign cmd_bit  = cmd_sync_q[1];
    // Complete frame as it stands when the end bit is being sampled.
    assign rx_frame = {rx_shift_q, cmd_bit};

`ifdef SD_CMD_RX_CRC_EN
    logic [6:0] rx_crc_q, rx_crc_d;
    assign frame_ok = ~rx_frame[47] & rx_frame[46] & rx_frame[0] & (rx_crc_q == rx_frame[7:1]);
`else
    logic unused_rx_crc;
    assign unused_rx_crc = ^rx_frame[7:1];
    assign frame_ok = ~rx_frame[47] & rx_frame[46] & rx_frame[0];
`endif

    // Response handshake: a response is taken on any clk edge where resp_ready is high and
    // resp_valid or resp_drop is high; drop wins, and resp_ready falls in the following cycle.
    always_comb begin
        state_d       = state_q;
        sd_clk_sync_d = {sd_clk_sync_q[1:0], sd_clk};
        cmd_sync_d    = {cmd_sync_q[0], sd_cmd_in};
        rx_shift_d    = rx_shift_q;
        rx_cnt_d      = rx_cnt_q;
        tx_shift_d    = tx_shift_q;
        tx_crc_d      = tx_crc_q;
        tx_cnt_d      = tx_cnt_q;
        ncr_cnt_d     = ncr_cnt_q;
        sd_cmd_out_d  = sd_cmd_out_q;
        sd_cmd_oe_d   = sd_cmd_oe_q;
        cmd_valid_d   = 1'b0;
        cmd_err_d     = 1'b0;
        cmd_index_d   = cmd_index_q;
        cmd_arg_d     = cmd_arg_q;
        resp_ready_d  = resp_ready_q;
`ifdef SD_CMD_RX_CRC_EN
        rx_crc_d      = rx_crc_q;
`endif
        case (state_q)
            S_IDLE, S_WAIT: begin
                if (state_q == S_WAIT && resp_drop) begin
                    resp_ready_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (state_q == S_WAIT && resp_valid) begin
                    resp_ready_d = 1'b0;
                    tx_shift_d   = {2'b00, resp_index, resp_arg};
                    ncr_cnt_d    = '0;
                    state_d      = S_NCR;
                end else if (rise && !cmd_bit) begin
                    resp_ready_d = 1'b0;
                    rx_shift_d   = {46'd0, cmd_bit};
                    rx_cnt_d     = 6'd1;
`ifdef SD_CMD_RX_CRC_EN
                    rx_crc_d     = crc7_step(7'd0, cmd_bit);
`endif
                    state_d      = S_RX;
                end
            end
            S_RX: begin
                if (rise) begin
                    rx_shift_d = {rx_shift_q[45:0], cmd_bit};
                    rx_cnt_d   = rx_cnt_q + 6'd1;
`ifdef SD_CMD_RX_CRC_EN
                    if (rx_cnt_q < 6'd40) rx_crc_d = crc7_step(rx_crc_q, cmd_bit);
`endif
                    if (rx_cnt_q == 6'd47) begin
                        state_d = S_CHECK;
                        if (frame_ok) begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = rx_frame[45:40];
                            cmd_arg_d   = rx_frame[39:8];
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
            end
            S_CHECK: begin
                // cmd_valid is high during this cycle only when the frame passed.
                resp_ready_d = cmd_valid_q;
                state_d      = cmd_valid_q ? S_WAIT : S_IDLE;
            end
            S_NCR: begin
                if (fall) begin
                    ncr_cnt_d = ncr_cnt_q + 6'd1;
                    if (ncr_cnt_q == 6'(NCR - 1)) begin
                        sd_cmd_out_d = tx_shift_q[39];
                        sd_cmd_oe_d  = 1'b1;
                        tx_crc_d     = crc7_step(7'd0, tx_shift_q[39]);
                        tx_shift_d   = {tx_shift_q[38:0], 1'b0};
                        tx_cnt_d     = 6'd1;
                        state_d      = S_TX;
                    end
                end
            end
            S_TX: begin
                if (fall) begin
                    tx_cnt_d = tx_cnt_q + 6'd1;
                    if (tx_cnt_q < 6'd40) begin
                        sd_cmd_out_d = tx_shift_q[39];
                        tx_crc_d     = crc7_step(tx_crc_q, tx_shift_q[39]);
                        tx_shift_d   = {tx_shift_q[38:0], 1'b0};
                    end else if (tx_cnt_q < 6'd47) begin
                        sd_cmd_out_d = tx_crc_q[6];
                        tx_crc_d     = {tx_crc_q[5:0], 1'b0};
                    end else if (tx_cnt_q == 6'd47) begin
                        sd_cmd_out_d = 1'b1;
                    end else begin
                        sd_cmd_out_d = 1'b1;
                        sd_cmd_oe_d  = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sd_clk_sync_q <= '0;
            cmd_sync_q    <= 2'b11;
            rx_shift_q    <= '0;
            rx_cnt_q      <= '0;
            tx_shift_q    <= '0;
            tx_crc_q      <= '0;
            tx_cnt_q      <= '0;
            ncr_cnt_q     <= '0;
            sd_cmd_out_q  <= 1'b1;
            sd_cmd_oe_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_index_q   <= '0;
            cmd_arg_q     <= '0;
            resp_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sd_clk_sync_q <= sd_clk_sync_d;
            cmd_sync_q    <= cmd_sync_d;
            rx_shift_q    <= rx_shift_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_shift_q    <= tx_shift_d;
            tx_crc_q      <= tx_crc_d;
            tx_cnt_q      <= tx_cnt_d;
            ncr_cnt_q     <= ncr_cnt_d;
            sd_cmd_out_q  <= sd_cmd_out_d;
            sd_cmd_oe_q   <= sd_cmd_oe_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_err_q     <= cmd_err_d;
            cmd_index_q   <= cmd_index_d;
            cmd_arg_q     <= cmd_arg_d;
            resp_ready_q  <= resp_ready_d;
        end
    end

`ifdef SD_CMD_RX_CRC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_crc_q <= '0;
        else          rx_crc_q <= rx_crc_d;
    end
`endif

    assign sd_cmd_out = sd_cmd_out_q;
    assign sd_cmd_oe  = sd_cmd_oe_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_err    = cmd_err_q;
    assign cmd_index  = cmd_index_q;
    assign cmd_arg    = cmd_arg_q;
    assign resp_ready = resp_ready_q;
    assign dbg_state  = state_q;
endmodule
